// File: rtl/sigmoid_taylor_pkg.sv
// Shared constants for the Taylor/SGU sigmoid datapath: lambda table, shift tables, mode encoding.
// Used by sigmoid_taylor_pipe (optional `SIGMOID_TAYLOR_SAT_EN) and sigmoid_taylor_msu.
package sigmoid_taylor_pkg;

  typedef enum logic {
    MODE_SIGMOID = 1'b0,
    MODE_TANH    = 1'b1
  } mode_e;

  localparam int SAT_N    = 12;
  localparam int LAMBDA_W = 16;

  // lambda[n] = floor(2^16 * 2^n / (2^n + 1)): sigmoid value at the segment start.
  localparam logic [LAMBDA_W-1:0] SGU_LAMBDA [16] = '{
    16'h8000, 16'hAAAA, 16'hCCCC, 16'hE38E,
    16'hF0F0, 16'hF83E, 16'hFC0F, 16'hFE03,
    16'hFF00, 16'hFF80, 16'hFFC0, 16'hFFE0,
    16'hFFF0, 16'hFFF8, 16'hFFFC, 16'hFFFE
  };

  // A shift of SH_OFF clears the term for any supported accumulator width.
  localparam logic [5:0] SH_OFF = 6'd63;

  localparam logic [5:0] W_SHIFT [16] = '{
    6'd2,   6'd3,   6'd4,   6'd5,
    6'd5,   6'd6,   6'd7,   6'd8,
    6'd9,   6'd10,  6'd11,  6'd12,
    SH_OFF, SH_OFF, SH_OFF, SH_OFF
  };

  localparam logic [5:0] V_SHIFT [16] = '{
    SH_OFF, 6'd7,   6'd5,   6'd6,
    SH_OFF, SH_OFF, SH_OFF, SH_OFF,
    SH_OFF, SH_OFF, SH_OFF, SH_OFF,
    SH_OFF, SH_OFF, SH_OFF, SH_OFF
  };

endpackage

// File: rtl/sigmoid_taylor_msu.sv
// Combinational multiply-shift unit: S = (t >> ws[n]) + (t >> vs[n]) + lambda[n], mod 2^ACC_W.
module sigmoid_taylor_msu
  import sigmoid_taylor_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] i_t,
  input  logic [3:0]       i_n,
  output logic [ACC_W-1:0] o_sum
);

  logic [ACC_W-1:0] w_w;
  logic [ACC_W-1:0] w_v;
  logic [ACC_W-1:0] w_lambda;

  always_comb begin
    w_w      = i_t >> W_SHIFT[i_n];
    w_v      = i_t >> V_SHIFT[i_n];
    // The table is stored at 16 bits and scaled up to the accumulator width.
    w_lambda = ACC_W'(SGU_LAMBDA[i_n]) << (ACC_W - LAMBDA_W);
    o_sum    = w_w + w_v + w_lambda;
  end

endmodule

// File: rtl/sigmoid_taylor_pipe.sv
// 3-stage pipelined sigmoid/tanh (Taylor/SGU) with valid/ready flow control and a tag sideband.
// Define SIGMOID_TAYLOR_SAT_EN to force saturated outputs when n >= SAT_N.
module sigmoid_taylor_pipe
  import sigmoid_taylor_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 12,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ACC_W = OUT_W + 4;
  localparam logic [IN_W-1:0] XP_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] XP_MIN = {1'b1, {(IN_W-2){1'b0}}, 1'b1};
  localparam logic [IN_W-1:0] XP_NEG = {1'b1, {(IN_W-1){1'b0}}};

  // Handshake: a word moves across a boundary on the cycle where valid & ready are both high;
  // a stage loads when it is empty or its occupant moves on, so bubbles collapse.
  logic w_s1_en, w_s2_en, w_s3_en;

  logic             r_s1_v, r_s1_p, r_s1_mode;
  logic [3:0]       r_s1_n;
  logic [IN_W-1:0]  r_s1_phi_xi;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_v, r_s2_p, r_s2_mode;
  logic [ACC_W-1:0] r_s2_s;
  logic [TAG_W-1:0] r_s2_tag;
`ifdef SIGMOID_TAYLOR_SAT_EN
  logic             r_s2_sat;
`endif

  logic             r_s3_v;
  logic [OUT_W-1:0] r_s3_y;
  logic [TAG_W-1:0] r_s3_tag;

  logic [IN_W-1:0]     w_x2, w_xp, w_xi, w_m, w_phi_xi;
  logic [FRAC_W+3:0]   w_m_ext;
  logic [3:0]          w_n;
  logic                w_p;
  logic [ACC_W-1:0]    w_t, w_sum;
  logic [OUT_W-1:0]    w_q, w_y;

  assign w_s3_en  = !r_s3_v | out_ready;
  assign w_s2_en  = !r_s2_v | w_s3_en;
  assign w_s1_en  = !r_s1_v | w_s2_en;
  assign in_ready = w_s1_en;

  // S1: tanh pre-scale with saturation, sign/magnitude split, x*log2(e) estimate.
  always_comb begin
    w_x2 = {in_x[IN_W-2:0], 1'b0};
    w_xp = in_x;
    if (in_mode == MODE_TANH) begin
      if (in_x[IN_W-1] != in_x[IN_W-2]) w_xp = in_x[IN_W-1] ? XP_MIN : XP_MAX;
      else if (w_x2 == XP_NEG)           w_xp = XP_MIN;
      else                               w_xp = w_x2;
    end
    w_p = w_xp[IN_W-1];
    if (!w_p)                 w_xi = w_xp;
    else if (w_xp == XP_NEG)  w_xi = XP_MAX;
    else                      w_xi = -w_xp;
    w_m      = w_xi + (w_xi >> 1) - (w_xi >> 4);
    w_m_ext  = (FRAC_W+4)'(w_m);
    w_n      = w_m_ext[FRAC_W+3:FRAC_W];
    w_phi_xi = (w_n == 4'd0) ? w_xi : {w_m_ext[FRAC_W-1:0], {(IN_W-FRAC_W){1'b0}}};
  end

  assign w_t = {r_s1_phi_xi, {(ACC_W-IN_W){1'b0}}};

  sigmoid_taylor_msu #(.ACC_W(ACC_W)) u_msu (
    .i_t   (w_t),
    .i_n   (r_s1_n),
    .o_sum (w_sum)
  );

  // S3: negating the upper field only needs the carry out of the dropped low nibble.
  always_comb begin
    if (r_s2_p) w_q = ~r_s2_s[ACC_W-1:4] + {{(OUT_W-1){1'b0}}, (r_s2_s[3:0] == 4'd0)};
    else        w_q = r_s2_s[ACC_W-1:4];
`ifdef SIGMOID_TAYLOR_SAT_EN
    if (r_s2_sat) w_q = r_s2_p ? '0 : '1;
`endif
    w_y = (r_s2_mode == MODE_TANH) ? {~w_q[OUT_W-1], w_q[OUT_W-2:0]} : w_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_p      <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_n      <= '0;
      r_s1_phi_xi <= '0;
      r_s1_tag    <= '0;
      r_s2_v      <= 1'b0;
      r_s2_p      <= 1'b0;
      r_s2_mode   <= 1'b0;
      r_s2_s      <= '0;
      r_s2_tag    <= '0;
`ifdef SIGMOID_TAYLOR_SAT_EN
      r_s2_sat    <= 1'b0;
`endif
      r_s3_v      <= 1'b0;
      r_s3_y      <= '0;
      r_s3_tag    <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_v <= in_valid;
        if (in_valid) begin
          r_s1_p      <= w_p;
          r_s1_mode   <= in_mode;
          r_s1_n      <= w_n;
          r_s1_phi_xi <= w_phi_xi;
          r_s1_tag    <= in_tag;
        end
      end
      if (w_s2_en) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_s    <= w_sum;
          r_s2_p    <= r_s1_p;
          r_s2_mode <= r_s1_mode;
          r_s2_tag  <= r_s1_tag;
`ifdef SIGMOID_TAYLOR_SAT_EN
          r_s2_sat  <= (r_s1_n >= 4'(SAT_N));
`endif
        end
      end
      if (w_s3_en) begin
        r_s3_v <= r_s2_v;
        if (r_s2_v) begin
          r_s3_y   <= w_y;
          r_s3_tag <= r_s2_tag;
        end
      end
    end
  end

  assign out_valid = r_s3_v;
  assign out_y     = r_s3_y;
  assign out_tag   = r_s3_tag;

endmodule

// File: tb/tb_sigmoid_taylor_pipe.sv
// Directed bench for sigmoid_taylor_pipe: latency, ordering, arithmetic vectors, stall and reset.
`timescale 1ns/1ps
module tb_sigmoid_taylor_pipe;
  import sigmoid_taylor_pkg::*;

  localparam int IN_W  = 12;
  localparam int OUT_W = 12;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_x;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_y;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_errors = 0;
  int n_sent   = 0;
  int n_out    = 0;
  logic [TAG_W+OUT_W-1:0] exp_q[$];

  sigmoid_taylor_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // driver: entered and left at posedge+1
  task automatic send(input logic [IN_W-1:0] x, input logic mode, input logic [TAG_W-1:0] tag,
                      input logic [OUT_W-1:0] exp_y, input bit track);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_x     = x;
    in_mode  = mode;
    in_tag   = tag;
    if (track) begin
      exp_q.push_back({tag, exp_y});
      n_sent++;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'(in_ready), 'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 'h0);
  endtask

  // scoreboard: outputs are sampled mid-cycle, before the edge that retires them
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 'h0);
      end else begin
        logic [TAG_W+OUT_W-1:0] e;
        e = exp_q.pop_front();
        check("sb_out_y", 32'(out_y), 32'(e[OUT_W-1:0]));
        check("sb_out_tag", 32'(out_tag), 32'(e[TAG_W+OUT_W-1:OUT_W]));
      end
    end
  end

  localparam logic [IN_W-1:0] VX [16] = '{
    12'h7FF, 12'h800, 12'h000, 12'h080, 12'h200, 12'hE00, 12'h300, 12'h180,
    12'h280, 12'h500, 12'h080, 12'hF80, 12'h100, 12'hF00, 12'h400, 12'hC00
  };
  localparam logic VM [16] = '{
    MODE_SIGMOID, MODE_SIGMOID, MODE_TANH,    MODE_TANH,
    MODE_SIGMOID, MODE_SIGMOID, MODE_SIGMOID, MODE_SIGMOID,
    MODE_SIGMOID, MODE_SIGMOID, MODE_SIGMOID, MODE_SIGMOID,
    MODE_TANH,    MODE_TANH,    MODE_TANH,    MODE_TANH
  };
  localparam logic [OUT_W-1:0] VY [16] = '{
    12'hFFE, 12'h001, 12'h000, 12'h398, 12'hE1C, 12'h1E3, 12'hF37, 12'hD08,
    12'hEAA, 12'hFE3, 12'h820, 12'h7E0, 12'h61C, 12'h9E3, 12'h7FE, 12'h801
  };

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_mode   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 'h0);
    check("rst_out_y", 32'(out_y), 'h0);
    check("rst_out_tag", 32'(out_tag), 'h0);
    check("rst_in_ready", 32'(in_ready), 'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency from a single transfer
    send(12'h000, MODE_SIGMOID, 4'h1, 12'h800, 1'b1);
    check("lat_c1_valid", 32'(out_valid), 'h0);
    @(posedge clk); #1;
    check("lat_c2_valid", 32'(out_valid), 'h0);
    @(posedge clk); #1;
    check("lat_c3_valid", 32'(out_valid), 'h1);
    check("lat_c3_y", 32'(out_y), 'h800);

    // back-to-back, results on consecutive cycles
    send(12'h100, MODE_SIGMOID, 4'h2, 12'hB98, 1'b1);
    send(12'hF00, MODE_SIGMOID, 4'h3, 12'h467, 1'b1);
    @(posedge clk); #1;
    check("b2b_first_valid", 32'(out_valid), 'h1);
    check("b2b_first_y", 32'(out_y), 'hB98);
    check("b2b_first_tag", 32'(out_tag), 'h2);
    @(posedge clk); #1;
    check("b2b_second_valid", 32'(out_valid), 'h1);
    check("b2b_second_y", 32'(out_y), 'h467);
    check("b2b_second_tag", 32'(out_tag), 'h3);
    drain();

    // arithmetic vectors streamed at full rate
    for (int i = 0; i < 16; i++) send(VX[i], VM[i], 4'(i), VY[i], 1'b1);
    drain();

    // stall: output blocked, pipeline fills with three samples
    out_ready = 1'b0;
    send(12'h100, MODE_SIGMOID, 4'h4, 12'hB98, 1'b1);
    send(12'h200, MODE_SIGMOID, 4'h5, 12'hE1C, 1'b1);
    send(12'h300, MODE_SIGMOID, 4'h6, 12'hF37, 1'b1);
    check("stall_in_ready", 32'(in_ready), 'h0);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(out_valid), 'h1);
      check("stall_y", 32'(out_y), 'hB98);
      check("stall_tag", 32'(out_tag), 'h4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(12'h180, MODE_SIGMOID, 4'h7, 12'hD08, 1'b1);
    send(12'h280, MODE_SIGMOID, 4'h8, 12'hEAA, 1'b1);
    drain();

    // reset with three samples in flight
    out_ready = 1'b0;
    send(12'h100, MODE_SIGMOID, 4'h9, 12'hB98, 1'b0);
    send(12'h200, MODE_SIGMOID, 4'hA, 12'hE1C, 1'b0);
    send(12'h300, MODE_SIGMOID, 4'hB, 12'hF37, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 'h0);
    check("mid_rst_y", 32'(out_y), 'h0);
    check("mid_rst_tag", 32'(out_tag), 'h0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(12'h000, MODE_SIGMOID, 4'hC, 12'h800, 1'b1);
    check("post_rst_c1_valid", 32'(out_valid), 'h0);
    @(posedge clk); #1;
    check("post_rst_c2_valid", 32'(out_valid), 'h0);
    @(posedge clk); #1;
    check("post_rst_c3_valid", 32'(out_valid), 'h1);
    check("post_rst_c3_y", 32'(out_y), 'h800);
    check("post_rst_c3_tag", 32'(out_tag), 'hC);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("out_count", 32'(n_out), 32'(n_sent));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
